up_printer_adapter: RTL and testbench

//  Downstream consumer of the BK-0011M parallel port (UP) on connector XT5.

---
 rtl/up_printer_adapter.sv | 231 +++++++++++++++++++++++
 tb/tb_up_printer_adapter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/up_printer_adapter.sv
// up_printer_adapter
//   Bridges the BK-0011M parallel port (UP, connector XT5) to a Centronics-style
//   printer. CPU writes to the UP output register are captured on STROBE.
//   Data bytes are queued in a FIFO. Command words control the status flags and
//   the FIFO. Queued bytes are replayed to the printer with an nSTROBE/BUSY/nACK
//   handshake. A status word is driven back on the UP input lines for CPU polling.
//
// Build option:
//   UPPR_TIMEOUT_EN  when defined, a byte that is not acknowledged within
//                    TMO_CYC cycles is dropped, and the sticky TMO flag is set.
//
// Ports:
//   clk          system clock
//   nRST         synchronous active-low reset
//   XT5_out_pin  UP output register (bit15=1: command, else data byte in [7:0])
//   STROBE       UP write strobe, asynchronous, active high
//   XT5_in_pin   status: [0]FULL [1]EMPTY [2]OVF [3]BUSY [4]TMO [5]ACTIVE [12:8]COUNT
//   PR_DATA      printer data byte
//   nPR_STB      printer strobe, active low
//   PR_BUSY      printer busy, asynchronous
//   nPR_ACK      printer acknowledge, active low, asynchronous
module up_printer_adapter #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STB_CYC    = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned TMO_CYC    = 4000
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] XT5_out_pin,
  input  logic        STROBE,
  output logic [15:0] XT5_in_pin,
  output logic [7:0]  PR_DATA,
  output logic        nPR_STB,
  input  logic        PR_BUSY,
  input  logic        nPR_ACK
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PH_W  = $clog2(SETUP_CYC + STB_CYC + HOLD_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_STB   = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic strb_s1_q, strb_s2_q, strb_prev_q, rel_q, arm_q;
  logic busy_s1_q, busy_s2_q;
  logic ack_s1_q, ack_s2_q, ack_prev_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             ack_seen_q, ack_seen_d;
  logic [7:0]       data_q, data_d;
  logic             stb_n_q;
  logic [15:0]      stat_q, stat_d;
  logic [4:0]       cnt5;

  logic wr_evt, push_req, push, pop, flush, clr, full, empty, ack_fall;
  logic tmo_hit, tmo_d;

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^XT5_out_pin[14:8];

  // Synchronisers. arm_q blocks edge detection after reset until STROBE has
  // been seen low through both stages, so a strobe held across reset release
  // does not register as a write.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      strb_s1_q   <= 1'b0;
      strb_s2_q   <= 1'b0;
      strb_prev_q <= 1'b0;
      rel_q       <= 1'b0;
      arm_q       <= 1'b0;
      busy_s1_q   <= 1'b0;
      busy_s2_q   <= 1'b0;
      ack_s1_q    <= 1'b1;
      ack_s2_q    <= 1'b1;
      ack_prev_q  <= 1'b1;
    end else begin
      strb_s1_q   <= STROBE;
      strb_s2_q   <= strb_s1_q;
      strb_prev_q <= strb_s2_q;
      rel_q       <= 1'b1;
      if (rel_q && !strb_s1_q && !strb_s2_q) arm_q <= 1'b1;
      busy_s1_q   <= PR_BUSY;
      busy_s2_q   <= busy_s1_q;
      ack_s1_q    <= nPR_ACK;
      ack_s2_q    <= ack_s1_q;
      ack_prev_q  <= ack_s2_q;
    end
  end

  assign wr_evt   = strb_s2_q & ~strb_prev_q & arm_q;
  assign push_req = wr_evt & ~XT5_out_pin[15];
  assign flush    = wr_evt & XT5_out_pin[15] & XT5_out_pin[1];
  assign clr      = wr_evt & XT5_out_pin[15] & XT5_out_pin[0];
  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign ack_fall = ack_prev_q & ~ack_s2_q;
  assign pop      = (state_q == S_IDLE) & ~empty & ~busy_s2_q;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push     = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
      if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
    if (clr) ovf_d = 1'b0;
    if (push_req && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= XT5_out_pin[7:0];
  end

`ifdef UPPR_TIMEOUT_EN
  localparam int unsigned TC_W = $clog2(TMO_CYC + 1);
  logic [TC_W-1:0] tcnt_q;
  logic            tmo_q;

  assign tmo_hit = (state_q == S_WAIT) & ~(ack_fall | ack_seen_q) &
                   (tcnt_q == TC_W'(TMO_CYC - 1));
  assign tmo_d   = tmo_hit | (tmo_q & ~clr);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_q == S_WAIT) ? tcnt_q + TC_W'(1) : '0;
      tmo_q  <= tmo_d;
    end
  end
`else
  // TMO_CYC has no effect in this build.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TMO_CYC == 0);
  assign tmo_hit = 1'b0;
  assign tmo_d   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    ack_seen_d = ack_seen_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d     = mem_q[rd_ptr_q];
          state_d    = S_SETUP;
          ph_d       = '0;
          ack_seen_d = 1'b0;
        end
      end
      S_SETUP, S_STB, S_HOLD: begin
        // An early acknowledge is remembered and honoured in WAIT_ACK.
        if (ack_fall) ack_seen_d = 1'b1;
        ph_d = ph_q + PH_W'(1);
        if (state_q == S_SETUP && ph_q == PH_W'(SETUP_CYC - 1)) begin
          state_d = S_STB;
          ph_d    = '0;
        end else if (state_q == S_STB && ph_q == PH_W'(STB_CYC - 1)) begin
          state_d = S_HOLD;
          ph_d    = '0;
        end else if (state_q == S_HOLD && ph_q == PH_W'(HOLD_CYC - 1)) begin
          state_d = S_WAIT;
          ph_d    = '0;
        end
      end
      S_WAIT: begin
        if (ack_fall || ack_seen_q || tmo_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt5   = 5'(cnt_d);
  assign stat_d = {3'b000, cnt5, 2'b00, (state_d != S_IDLE), tmo_d, busy_s1_q,
                   ovf_d, (cnt_d == '0), (cnt_d == CNT_W'(FIFO_DEPTH))};

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      ph_q       <= '0;
      ack_seen_q <= 1'b0;
      data_q     <= 8'h00;
      stb_n_q    <= 1'b1;
      stat_q     <= 16'h0002;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      ph_q       <= ph_d;
      ack_seen_q <= ack_seen_d;
      data_q     <= data_d;
      stb_n_q    <= (state_d != S_STB);
      stat_q     <= stat_d;
    end
  end

  assign XT5_in_pin = stat_q;
  assign PR_DATA    = data_q;
  assign nPR_STB    = stb_n_q;

endmodule

// File: tb/tb_up_printer_adapter.sv
module tb_up_printer_adapter;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] XT5_out_pin = 16'h0000;
  logic        STROBE = 1'b0;
  logic [15:0] XT5_in_pin;
  logic [7:0]  PR_DATA;
  logic        nPR_STB;
  logic        PR_BUSY = 1'b0;
  logic        nPR_ACK = 1'b1;

  int n_chk = 0;
  int n_fail = 0;
  bit ack_en = 1'b0;
  logic stb_prev_r = 1'b1;
  logic [7:0] rx[$];

  up_printer_adapter #(
    .FIFO_DEPTH(8), .SETUP_CYC(2), .STB_CYC(4), .HOLD_CYC(2), .TMO_CYC(16)
  ) dut (
    .clk(clk), .nRST(nRST), .XT5_out_pin(XT5_out_pin), .STROBE(STROBE),
    .XT5_in_pin(XT5_in_pin), .PR_DATA(PR_DATA), .nPR_STB(nPR_STB),
    .PR_BUSY(PR_BUSY), .nPR_ACK(nPR_ACK)
  );

  always #5 clk = ~clk;

  // Printer side: capture data on the strobe falling edge.
  always @(negedge clk) begin
    if (stb_prev_r === 1'b1 && nPR_STB === 1'b0) rx.push_back(PR_DATA);
    stb_prev_r <= nPR_STB;
  end

  // Printer acknowledge, 5 clk after nPR_STB rises, 2 clk wide.
  always begin
    @(posedge nPR_STB);
    if (ack_en) begin
      repeat (5) @(posedge clk);
      #1 nPR_ACK = 1'b0;
      repeat (2) @(posedge clk);
      #1 nPR_ACK = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] w);
    XT5_out_pin = w;
    STROBE = 1'b1;
    tick(1);
    STROBE = 1'b0;
  endtask

  task automatic wr_settle(input logic [15:0] w);
    wr(w);
    tick(4);
  endtask

  task automatic wait_stat(input string nm, input logic [15:0] v, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (XT5_in_pin === v) begin ok = 1'b1; break; end
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_stb_low(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nPR_STB === 1'b0) begin ok = 1'b1; break; end
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] word;
    logic        busy;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int n;
    bit ok;

    tbl[0]  = '{16'h0001, 1'b1, 16'h0108};
    tbl[1]  = '{16'h0002, 1'b1, 16'h0208};
    tbl[2]  = '{16'h0003, 1'b1, 16'h0308};
    tbl[3]  = '{16'h0004, 1'b1, 16'h0408};
    tbl[4]  = '{16'h0005, 1'b1, 16'h0508};
    tbl[5]  = '{16'h0006, 1'b1, 16'h0608};
    tbl[6]  = '{16'h0007, 1'b1, 16'h0708};
    tbl[7]  = '{16'h0008, 1'b1, 16'h0809};
    tbl[8]  = '{16'h0009, 1'b1, 16'h080D};
    tbl[9]  = '{16'h8001, 1'b1, 16'h0809};
    tbl[10] = '{16'h8000, 1'b1, 16'h0809};
    tbl[11] = '{16'h000A, 1'b1, 16'h080D};
    tbl[12] = '{16'h8001, 1'b1, 16'h0809};

    // Reset
    nRST = 1'b0;
    tick(2);
    chk("rst_stat", XT5_in_pin, 16'h0002);
    chk("rst_stb", nPR_STB, 1'b1);
    chk("rst_data", PR_DATA, 8'h00);
    nRST = 1'b1;
    tick(3);
    chk("rst_rel_stat", XT5_in_pin, 16'h0002);

    // Single byte with handshake timing
    ack_en = 1'b1;
    wr(16'h0041);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (PR_DATA === 8'h41) begin ok = 1'b1; break; end
    end
    chk("t2_data_seen", {31'd0, ok}, 32'd1);
    n = 0;
    while (nPR_STB === 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("t2_setup_cyc", n, 2);
    n = 0;
    while (nPR_STB === 1'b0 && n < 10) begin @(negedge clk); n++; end
    chk("t2_stb_width", n, 4);
    wait_stat("t2_done", 16'h0002, 60);
    chk("t2_data_held", PR_DATA, 8'h41);
    chk("t2_rx", rx.size(), 1);

    // Overflow and command table, printer busy
    PR_BUSY = 1'b1;
    tick(4);
    chk("busy_sync", XT5_in_pin, 16'h000A);
    for (int i = 0; i < 13; i++) begin
      PR_BUSY = tbl[i].busy;
      wr_settle(tbl[i].word);
      chk($sformatf("tbl%0d_w%h", i, tbl[i].word), XT5_in_pin, tbl[i].exp);
    end

    // Replay: 01..08 in order, dropped bytes never appear
    rx.delete();
    PR_BUSY = 1'b0;
    wait_stat("t3_drain", 16'h0002, 800);
    chk("t3_rx_n", rx.size(), 8);
    for (int i = 0; i < 8 && i < rx.size(); i++)
      chk($sformatf("t3_rx%0d", i), rx[i], 8'(i + 1));

    // Flush while a byte is in flight
    PR_BUSY = 1'b1;
    tick(4);
    wr_settle(16'h00A1);
    wr_settle(16'h00A2);
    wr_settle(16'h00A3);
    chk("t4_fill", XT5_in_pin, 16'h0308);
    rx.delete();
    PR_BUSY = 1'b0;
    wait_stb_low("t4_inflight");
    wr_settle(16'h8002);
    chk("t4_flush", XT5_in_pin, 16'h0022);
    wait_stat("t4_done", 16'h0002, 60);
    chk("t4_rx_n", rx.size(), 1);
    if (rx.size() > 0) chk("t4_rx0", rx[0], 8'hA1);

    // Reset in the middle of the strobe pulse
    ack_en = 1'b0;
    wr(16'h0033);
    wait_stb_low("t5_stb");
    nRST = 1'b0;
    @(negedge clk);
    chk("t5_stb", nPR_STB, 1'b1);
    chk("t5_stat", XT5_in_pin, 16'h0002);
    chk("t5_data", PR_DATA, 8'h00);
    STROBE = 1'b1;
    tick(1);
    nRST = 1'b1;
    tick(5);
    STROBE = 1'b0;
    tick(6);
    chk("t5_nowrite", XT5_in_pin, 16'h0002);
    chk("t5_nostb", nPR_STB, 1'b1);
    ack_en = 1'b1;
    rx.delete();
    wr(16'h0044);
    tick(2);
    wait_stat("t5_after", 16'h0002, 60);
    chk("t5_rx_n", rx.size(), 1);
    if (rx.size() > 0) chk("t5_rx0", rx[0], 8'h44);

    // Never-acknowledged byte
    ack_en = 1'b0;
    wr_settle(16'h0055);
    wr_settle(16'h0066);
`ifdef UPPR_TIMEOUT_EN
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (XT5_in_pin[4] === 1'b1) begin ok = 1'b1; break; end
    end
    chk("t6_tmo_set", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (PR_DATA === 8'h66) begin ok = 1'b1; break; end
    end
    chk("t6_next_byte", {31'd0, ok}, 32'd1);
    wr_settle(16'h8001);
    chk("t6_tmo_clr", XT5_in_pin[4], 1'b0);
`else
    tick(80);
    chk("t6_active", XT5_in_pin[5], 1'b1);
    chk("t6_tmo_zero", XT5_in_pin[4], 1'b0);
    chk("t6_data", PR_DATA, 8'h55);
    chk("t6_count", XT5_in_pin[12:8], 5'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
